aer_receiver: RTL and testbench
===============================

# aer_receiver

Receive end of the 4-event AER link: takes the bundled-data address (`bit0`, `bit1`) plus request strobe from an AER sender, completes a 4-phase req/ack handshake, and decodes each transfer back into one of four single-cycle event pulses (Ch1Up, Ch1Down, Ch2Up, Ch2Down). It sits on the FPGA side opposite the arbiter/sender pair and re-creates the original channel events in the local clock domain. It also keeps saturating per-channel event counts and a sticky handshake-timeout error.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth on `req`, `bit0`, `bit1` (≥2).
- `CNT_W`, 8: width of each per-channel event counter.
- `TIMEOUT`, 255: max cycles in ACK waiting for `req` release before error (1..2^16-1).

- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high; all state and outputs cleared on the clock edge where it is high.
- `req`  in  1  asynchronous request from sender, high = address valid.
- `bit0`, `bit1`  in  1 each  asynchronous address bits, held stable by sender while `req` high.
- `ack`  out  1  acknowledge to sender (registered).
- `ch1_up`, `ch1_down`, `ch2_up`, `ch2_down`  out  1 each  one-cycle event pulses.
- `event_addr`  out  2  address of last accepted event {bit1,bit0}.
- `cnt`  out  4*CNT_W  saturating counts; slice k = address k.
- `err`  out  1  sticky timeout flag.

## Operation
- Address map (fixed): 00 Ch1Up, 01 Ch1Down, 10 Ch2Up, 11 Ch2Down.
- `req`, `bit0`, `bit1` each pass through a SYNC_STAGES flop chain; FSM sees only `req_s`, `addr_s`.
- FSM states: IDLE, ACK, ERR.
  - IDLE: `ack`=0. If `req_s`=1: capture `addr_s` into `event_addr`, pulse decoded output, increment `cnt` slice, go ACK.
  - ACK: `ack`=1, timeout counter runs. `req_s`=0 → IDLE (ack drops next edge). Counter reaches TIMEOUT with `req_s` still 1 → set `err`, go ERR.
  - ERR: `ack`=0; wait `req_s`=0, then IDLE. No event decoded for the stuck transfer beyond the one already accepted.
- Exactly one pulse per accepted handshake; a `req` held high never yields a second event.
- Counters: each slice saturates at 2^CNT_W-1; no wrap.
- `err` cleared only by `reset`.
- Reset mid-handshake: FSM → IDLE, `ack`=0 next edge; if `req` still high after reset it is accepted as a new event (sender sees ack rise again).

## Timing
- Reset values: `ack`=0, all pulses 0, `event_addr`=00, `cnt`=0, `err`=0, FSM IDLE, sync chains 0.
- Cycle E = first cycle `req_s`=1 in IDLE. At edge ending E: `ack`=1, `event_addr` updated, one pulse high during E+1 only, `cnt` updated visible in E+1.
- `req` edge → `ack` edge: SYNC_STAGES+1 cycles (±1 for async sampling).
- Cycle R = first cycle `req_s`=0 in ACK: `ack`=0 from R+1.
- Timeout: ERR entered, `err`=1 and `ack`=0 from cycle E+1+TIMEOUT.
- Sender contract: address stable ≥ SYNC_STAGES cycles before `req` rise and until `ack` seen; `req` not re-raised until `ack` low. Back-to-back minimum: one full 4-phase cycle ≈ 2·(SYNC_STAGES+1) cycles.

## Structure
- Shared package `aer_pkg`: 2-bit address constants (ADDR_CH1_UP..ADDR_CH2_DOWN), FSM state enum; the sender side uses the same constants.
- Sub-module `aer_sync`: parameterized N-stage flop synchronizer, instantiated once per async input (3 instances).
- Decode, counters, timeout counter, FSM inline in `aer_receiver`.

## Test plan
- Reset: drive `reset` 2 cycles with `req`=1 → all outputs 0 during reset; after release, event accepted, `ack`=1 at SYNC_STAGES+1 cycles.
- Each address: 4 handshakes with addr 00,01,10,11 → `ch1_up`,`ch1_down`,`ch2_up`,`ch2_down` each pulse exactly once for 1 cycle; `cnt`=1 in every slice; `event_addr` tracks.
- Held request: `req`=1 for 50 cycles, TIMEOUT=255 → single pulse, `ack` high until 3 cycles after `req` drop, `err`=0.
- Timeout: TIMEOUT=16, `req` stuck high → `err`=1 and `ack`=0 at E+17; release `req` → IDLE; next handshake works, `err` stays 1.
- Saturation: CNT_W=4, 20 events on addr 10 → slice 2 stops at 15, other slices 0.
- Reset mid-ACK: assert `reset` while `ack`=1, `req` high → `ack`=0, `cnt` cleared next edge; after release same `req` produces one new event.

Source files
------------

// File: rtl/aer_pkg.sv
// rtl/aer_pkg.sv - shared AER address map and receiver FSM state encoding
package aer_pkg;

  localparam logic [1:0] ADDR_CH1_UP   = 2'b00;
  localparam logic [1:0] ADDR_CH1_DOWN = 2'b01;
  localparam logic [1:0] ADDR_CH2_UP   = 2'b10;
  localparam logic [1:0] ADDR_CH2_DOWN = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

endpackage

// File: rtl/aer_sync.sv
// rtl/aer_sync.sv - N-stage flop synchronizer for one asynchronous input
module aer_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[N-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/aer_receiver.sv
// rtl/aer_receiver.sv - AER link receiver: 4-phase req/ack handshake, event decode,
// saturating per-channel counts and sticky handshake-timeout error
module aer_receiver
  import aer_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT     = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic               bit0,
  input  logic               bit1,
  output logic               ack,
  output logic               ch1_up,
  output logic               ch1_down,
  output logic               ch2_up,
  output logic               ch2_down,
  output logic [1:0]         event_addr,
  output logic [4*CNT_W-1:0] cnt,
  output logic               err
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic       req_s;
  logic       bit0_s;
  logic       bit1_s;
  logic [1:0] addr_s;

  aer_sync #(.N(SYNC_STAGES)) u_sync_req  (.clk(clk), .reset(reset), .d(req),  .q(req_s));
  aer_sync #(.N(SYNC_STAGES)) u_sync_bit0 (.clk(clk), .reset(reset), .d(bit0), .q(bit0_s));
  aer_sync #(.N(SYNC_STAGES)) u_sync_bit1 (.clk(clk), .reset(reset), .d(bit1), .q(bit1_s));

  assign addr_s = {bit1_s, bit0_s};

  state_e                  state_q, state_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic [3:0]              pulse_q, pulse_d;
  logic [1:0]              event_addr_q, event_addr_d;
  logic [15:0]             tmo_q, tmo_d;
  logic [3:0][CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d      = state_q;
    ack_d        = ack_q;
    err_d        = err_q;
    pulse_d      = 4'b0000;
    event_addr_d = event_addr_q;
    tmo_d        = tmo_q;
    cnt_d        = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        ack_d = 1'b0;
        if (req_s) begin
          event_addr_d = addr_s;
          pulse_d      = 4'b0001 << addr_s;
          if (cnt_q[addr_s] != {CNT_W{1'b1}}) begin
            cnt_d[addr_s] = cnt_q[addr_s] + CNT_W'(1);
          end
          tmo_d   = '0;
          ack_d   = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        // Release wins over timeout when both happen in the same cycle.
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          ack_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ST_ERR;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      ST_ERR: begin
        ack_d = 1'b0;
        if (!req_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      pulse_q      <= 4'b0000;
      event_addr_q <= 2'b00;
      tmo_q        <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      pulse_q      <= pulse_d;
      event_addr_q <= event_addr_d;
      tmo_q        <= tmo_d;
      cnt_q        <= cnt_d;
    end
  end

  assign ack        = ack_q;
  assign err        = err_q;
  assign event_addr = event_addr_q;
  assign cnt        = cnt_q;
  assign ch1_up     = pulse_q[ADDR_CH1_UP];
  assign ch1_down   = pulse_q[ADDR_CH1_DOWN];
  assign ch2_up     = pulse_q[ADDR_CH2_UP];
  assign ch2_down   = pulse_q[ADDR_CH2_DOWN];

endmodule

// File: tb/tb_aer_receiver.sv
// tb/tb_aer_receiver.sv - scoreboard bench: sender model drives handshakes, a monitor
// pops expected events whenever the receiver pulses
module tb_aer_receiver;

  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 4;
  localparam int TIMEOUT     = 16;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               req;
  logic               bit0;
  logic               bit1;
  logic               ack;
  logic               ch1_up, ch1_down, ch2_up, ch2_down;
  logic [1:0]         event_addr;
  logic [4*CNT_W-1:0] cnt;
  logic               err;
  logic [3:0]         pulses;

  aer_receiver #(
    .SYNC_STAGES(SYNC_STAGES),
    .CNT_W      (CNT_W),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .bit0      (bit0),
    .bit1      (bit1),
    .ack       (ack),
    .ch1_up    (ch1_up),
    .ch1_down  (ch1_down),
    .ch2_up    (ch2_up),
    .ch2_down  (ch2_down),
    .event_addr(event_addr),
    .cnt       (cnt),
    .err       (err)
  );

  always #5 clk = ~clk;

  assign pulses = {ch2_down, ch2_up, ch1_down, ch1_up};

  typedef struct {
    logic [1:0]         addr;
    logic [4*CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cnt_m[4];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [4*CNT_W-1:0] model_cnt();
    logic [4*CNT_W-1:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) v[k*CNT_W +: CNT_W] = CNT_W'(cnt_m[k]);
    return v;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 4; k++) cnt_m[k] = 0;
  endtask

  task automatic model_event(input logic [1:0] a);
    exp_t e;
    if (cnt_m[a] < CNT_MAX) cnt_m[a]++;
    e.addr = a;
    e.cnt  = model_cnt();
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic level, output int n);
    n = 0;
    while (ack !== level && n < 40) begin
      tick();
      n++;
    end
  endtask

  // Full 4-phase handshake; hold_cycles keeps req high after ack is seen.
  task automatic handshake(input logic [1:0] a, input int hold_cycles);
    int n;
    bit0 = a[0];
    bit1 = a[1];
    repeat (SYNC_STAGES) tick();
    req = 1'b1;
    model_event(a);
    wait_ack(1'b1, n);
    chk("ack_rise_latency", n, SYNC_STAGES + 1);
    for (int i = 0; i < hold_cycles; i++) begin
      tick();
      chk("ack_held", ack, 1'b1);
    end
    req = 1'b0;
    wait_ack(1'b0, n);
    chk("ack_fall_latency", n, SYNC_STAGES + 1);
    tick();
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) begin
      tick();
      chk("rst_ack", ack, 1'b0);
      chk("rst_pulses", pulses, 4'b0);
      chk("rst_cnt", cnt, '0);
      chk("rst_err", err, 1'b0);
      chk("rst_addr", event_addr, 2'b00);
    end
    model_clear();
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && pulses != 4'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", pulses, 4'b0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pulse_onehot", pulses, 32'(4'b0001 << mon_e.addr));
        chk("event_addr", event_addr, mon_e.addr);
        chk("cnt", cnt, mon_e.cnt);
      end
    end
  end

  initial begin
    int n;
    logic [1:0] a;
    reset = 1'b1;
    req   = 1'b0;
    bit0  = 1'b0;
    bit1  = 1'b0;
    model_clear();

    // Reset with req already high: accepted as soon as reset releases.
    req  = 1'b1;
    bit0 = 1'b1;
    do_reset(2);
    model_event(2'b01);
    wait_ack(1'b1, n);
    chk("post_reset_ack_latency", n, SYNC_STAGES + 1);
    req = 1'b0;
    wait_ack(1'b0, n);
    chk("post_reset_ack_fall", n, SYNC_STAGES + 1);
    tick();

    do_reset(1);
    for (int i = 0; i < 4; i++) handshake(2'(i), 0);
    chk("cnt_all_one", cnt, model_cnt());

    // Held request never yields a second event.
    handshake(2'($urandom_range(0, 3)), 12);
    chk("held_no_err", err, 1'b0);

    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      handshake(2'($urandom_range(0, 3)), $urandom_range(0, 4));
    end
    chk("random_cnt", cnt, model_cnt());

    // Stuck request: timeout, then recovery with err sticky.
    bit0 = 1'b1;
    bit1 = 1'b1;
    repeat (SYNC_STAGES) tick();
    req = 1'b1;
    model_event(2'b11);
    wait_ack(1'b1, n);
    chk("tmo_ack_latency", n, SYNC_STAGES + 1);
    n = 0;
    while (err !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk("tmo_err_cycle", n, TIMEOUT);
    chk("tmo_ack_low", ack, 1'b0);
    repeat (5) begin
      tick();
      chk("err_state_ack_low", ack, 1'b0);
    end
    req = 1'b0;
    repeat (4) tick();
    chk("tmo_err_sticky", err, 1'b1);
    handshake(2'b00, 0);
    chk("tmo_err_after_hs", err, 1'b1);

    // Saturation of one slice.
    do_reset(1);
    for (int i = 0; i < 20; i++) handshake(2'b10, 0);
    chk("sat_slice2", cnt[2*CNT_W +: CNT_W], CNT_MAX);
    chk("sat_full", cnt, model_cnt());

    // Reset while ack is high and req still asserted.
    a    = 2'($urandom_range(0, 3));
    bit0 = a[0];
    bit1 = a[1];
    repeat (SYNC_STAGES) tick();
    req = 1'b1;
    model_event(a);
    wait_ack(1'b1, n);
    chk("midack_ack_latency", n, SYNC_STAGES + 1);
    tick();
    do_reset(1);
    model_event(a);
    wait_ack(1'b1, n);
    chk("midack_reaccept", n, SYNC_STAGES + 1);
    req = 1'b0;
    wait_ack(1'b0, n);
    chk("midack_ack_fall", n, SYNC_STAGES + 1);
    repeat (4) tick();
    chk("midack_cnt", cnt, model_cnt());

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
